fmanorm_pipe: RTL and testbench
===============================

# fmanorm_pipe

Pipelined, parametrised leading-zero normalizer for the fma datapath. Takes an unnormalized significand sum, left-shifts it so the MSB is 1, and reports the shift count and a biased exponent adjustment. It has one register stage per shift level, valid/ready elastic handshaking on both sides, a zero-detect flag, sideband tag pass-through, and a synchronous flush. It sits between the significand adder and the rounding stage, and replaces the combinational normalizer for wider and pipelined formats.

## Interface
Parameters:
- WIDTH, 34, significand width in bits (≥ 4)
- EWIDTH, 7, width of the exponent-adjust output
- OFFSET, 12, constant subtracted from the shift count to form the adjust value
- TAGW, 4, sideband tag width (≥ 1)
- Derived: L = clog2(WIDTH) shift levels and register stages; CW = clog2(WIDTH+1)

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous: discard all in-flight entries
- in_valid  input  1  input entry present
- in_ready  output  1  block accepts input this cycle
- in_sm  input  WIDTH  unnormalized significand
- in_tag  input  TAGW  sideband, carried unchanged
- out_valid  output  1  output entry present
- out_ready  input  1  consumer accepts output
- out_sm  output  WIDTH  normalized significand
- out_count  output  CW  leading-zero count (shift applied)
- out_adj  output  EWIDTH  out_count − OFFSET, two's complement, mod 2^EWIDTH
- out_zero  output  1  input was all zeros
- out_tag  output  TAGW  tag of this entry

## Operation
- Level k (k = L−1 down to 0, shift s = 2^k): if the top s bits of the running value are all zero, shift it left by s and set count bit k. Otherwise pass it through.
- Stage j register holds the result after level L−1−j, plus partial count, zero flag, tag and valid bit.
- Zero flag: computed in stage 0 as ~|in_sm and carried forward. For zero input, out_sm = 0, out_count = WIDTH, out_adj = WIDTH − OFFSET; the natural shift count is overridden.
- Nonzero input: out_count ∈ [0, WIDTH−1], out_sm[WIDTH−1] = 1, out_sm = in_sm << out_count.
- out_adj is computed in the last stage from the final count, zero-extended to max(CW, EWIDTH) before subtraction, then truncated to EWIDTH.
- Elastic pipeline:
  - Stage j loads when it is empty or its contents advance this cycle.
  - Last stage advances when out_valid && out_ready.
  - in_ready = stage 0 loadable && !flush.
  - The ready chain is combinational.
- Order is preserved. There is no loss and no duplication under any out_ready pattern.
- flush: all stage valid bits clear at the next edge. An input presented during flush is not accepted (in_ready = 0). Data registers may hold stale values.
- No bubbles are required: full throughput is 1 entry/cycle with out_ready held high.

## Timing
- Latency: an entry accepted at edge t appears with out_valid = 1 after edge t+L−1, i.e. L cycles of registers, provided there is no backpressure. For WIDTH = 34, L = 6.
- Outputs are registered: out_* come directly from last-stage flops, with no combinational path from in_* to out_*.
- out_valid && !out_ready: all out_* hold stable until the transfer.
- Reset (reset_n low, asynchronous):
  - All valid bits = 0 and all data/count/tag registers = 0.
  - Resulting outputs: out_valid = 0, out_sm = 0, out_count = 0, out_adj = 0, out_zero = 0, out_tag = 0.
  - in_ready = 1 after reset release, unless flush is high.
- Reset mid-stream drops all in-flight entries immediately, without waiting for a clock edge.
- Simultaneous flush and out_ready: the transfer of the current output completes on that edge; nothing else survives.

## Test plan
- WIDTH=34, OFFSET=12: in_sm = 1<<33 -> out_count = 0, out_adj = 7'h74 (−12), out_sm = 1<<33, out_zero = 0, 6 cycles after accept.
- in_sm = 34'h1 -> out_count = 33, out_adj = 21, out_sm = 1<<33. in_sm = 34'h0 -> out_zero = 1, out_count = 34, out_adj = 22, out_sm = 0.
- Streaming: 64 random inputs with distinct tags, out_ready held at 1 -> one output per cycle after 6-cycle fill. Each output matches the reference model (shift = count of leading zeros, tag unchanged).
- Backpressure: same stream with out_ready randomly toggled at 50% -> in-order outputs, no drops or duplicates, and out_* stable while out_valid && !out_ready.
- Flush with 4 entries in flight, asserted for 1 cycle -> out_valid = 0 from the next cycle. in_ready = 0 during the flush cycle. The next accepted entry emerges L cycles later.
- Assert reset_n low mid-stream between clock edges -> out_valid falls immediately and all outputs read 0. After release, a new input of 34'h3_0000_0000 gives out_count = 0.

Source files
------------

// File: rtl/fmanorm_pipe.sv
// rtl/fmanorm_pipe.sv - pipelined leading-zero normalizer with elastic valid/ready handshake
// One register stage per shift level; count, zero flag and tag travel alongside the significand.
module fmanorm_pipe #(
   parameter int WIDTH  = 34,
   parameter int EWIDTH = 7,
   parameter int OFFSET = 12,
   parameter int TAGW   = 4,
   localparam int L     = $clog2(WIDTH),
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_sm,
   input  logic [TAGW-1:0]   in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_sm,
   output logic [CW-1:0]     out_count,
   output logic [EWIDTH-1:0] out_adj,
   output logic              out_zero,
   output logic [TAGW-1:0]   out_tag
);

   localparam int AW = (CW > EWIDTH) ? CW : EWIDTH;

   logic [L-1:0]      vld;
   logic [L-1:0]      ld;
   logic [L-1:0]      src_vld;
   logic [WIDTH-1:0]  sm_q    [L];
   logic [CW-1:0]     cnt_q   [L];
   logic [L-1:0]      zero_q;
   logic [TAGW-1:0]   tag_q   [L];
   logic [EWIDTH-1:0] adj_q;

   logic [WIDTH-1:0]  src_sm  [L];
   logic [CW-1:0]     src_cnt [L];
   logic [L-1:0]      src_zero;
   logic [TAGW-1:0]   src_tag [L];
   logic [L-1:0]      hit;
   logic [WIDTH-1:0]  sm_d    [L];
   logic [CW-1:0]     cnt_d   [L];
   logic [AW-1:0]     adj_full;

   // A stage can load when empty or when its occupant moves on this cycle.
   always_comb begin
      ld = '0;
      ld[L-1] = !vld[L-1] || out_ready;
      for (int j = L - 2; j >= 0; j--) begin
         ld[j] = !vld[j] || ld[j+1];
      end
   end

   assign in_ready = ld[0] && !flush;
   assign src_vld  = {vld[L-2:0], in_valid && in_ready};

   always_comb begin
      src_sm[0]   = in_sm;
      src_cnt[0]  = '0;
      src_zero[0] = ~|in_sm;
      src_tag[0]  = in_tag;
      for (int j = 1; j < L; j++) begin
         src_sm[j]   = sm_q[j-1];
         src_cnt[j]  = cnt_q[j-1];
         src_zero[j] = zero_q[j-1];
         src_tag[j]  = tag_q[j-1];
      end
      // Stage j handles shift 2^(L-1-j): largest shift first.
      for (int j = 0; j < L; j++) begin
         hit[j]   = (src_sm[j] >> (WIDTH - (1 << (L - 1 - j)))) == '0;
         sm_d[j]  = hit[j] ? (src_sm[j] << (1 << (L - 1 - j))) : src_sm[j];
         cnt_d[j] = src_cnt[j] | (hit[j] ? CW'(1 << (L - 1 - j)) : CW'(0));
      end
      // All-zero input would otherwise report the saturated greedy count.
      if (src_zero[L-1]) begin
         cnt_d[L-1] = CW'(WIDTH);
      end
      adj_full = AW'(cnt_d[L-1]) - AW'(OFFSET);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld <= '0;
      end else if (flush) begin
         vld <= '0;
      end else begin
         for (int j = 0; j < L; j++) begin
            if (ld[j]) vld[j] <= src_vld[j];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < L; j++) begin
            sm_q[j]  <= '0;
            cnt_q[j] <= '0;
            tag_q[j] <= '0;
         end
         zero_q <= '0;
         adj_q  <= '0;
      end else begin
         for (int j = 0; j < L; j++) begin
            if (ld[j] && src_vld[j]) begin
               sm_q[j]   <= sm_d[j];
               cnt_q[j]  <= cnt_d[j];
               zero_q[j] <= src_zero[j];
               tag_q[j]  <= src_tag[j];
            end
         end
         if (ld[L-1] && src_vld[L-1]) begin
            adj_q <= adj_full[EWIDTH-1:0];
         end
      end
   end

   assign out_valid = vld[L-1];
   assign out_sm    = sm_q[L-1];
   assign out_count = cnt_q[L-1];
   assign out_adj   = adj_q;
   assign out_zero  = zero_q[L-1];
   assign out_tag   = tag_q[L-1];

endmodule

// File: tb/tb_fmanorm_pipe.sv
// tb/tb_fmanorm_pipe.sv - directed and streaming checks for fmanorm_pipe (WIDTH=34, OFFSET=12)
module tb_fmanorm_pipe;

   localparam int L = 6;

   logic        clk;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [33:0] in_sm;
   logic [7:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [33:0] out_sm;
   logic [5:0]  out_count;
   logic [6:0]  out_adj;
   logic        out_zero;
   logic [7:0]  out_tag;

   int checks = 0;
   int passes = 0;
   logic [33:0] vec [64];

   fmanorm_pipe #(.WIDTH(34), .EWIDTH(7), .OFFSET(12), .TAGW(8)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_sm(in_sm), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_sm(out_sm),
      .out_count(out_count), .out_adj(out_adj), .out_zero(out_zero), .out_tag(out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void ref_norm(input logic [33:0] v, output logic [33:0] sm,
                                    output logic [5:0] cnt, output logic [6:0] adj,
                                    output logic z);
      int c;
      int a;
      c = 0;
      z = (v == 34'h0);
      if (z) begin
         c  = 34;
         sm = '0;
      end else begin
         while (c < 34 && !v[33-c]) c++;
         sm = v << c;
      end
      cnt = 6'(c);
      a   = c - 12;
      adj = a[6:0];
   endfunction

   task automatic send_one(input logic [33:0] v, input logic [7:0] t, output int lat);
      @(negedge clk);
      flush = 0; in_valid = 1; in_sm = v; in_tag = t; out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      reset_n = 0; flush = 0; in_valid = 0; in_sm = '0; in_tag = '0; out_ready = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({out_valid, out_sm, out_count, out_adj, out_zero, out_tag} !== '0)
         $display("FAIL reset_outputs: got v=%b sm=%h cnt=%0d adj=%h z=%b tag=%h, expected all 0",
                  out_valid, out_sm, out_count, out_adj, out_zero, out_tag);
      else passes++;
      reset_n = 1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      else passes++;
   endtask

   task automatic test_directed();
      logic [33:0] dv [3];
      logic [33:0] esm [3];
      logic [5:0]  ecnt [3];
      logic [6:0]  eadj [3];
      logic        ez [3];
      int lat;
      dv[0] = 34'h2_0000_0000; esm[0] = 34'h2_0000_0000; ecnt[0] = 6'd0;  eadj[0] = 7'h74; ez[0] = 0;
      dv[1] = 34'h0_0000_0001; esm[1] = 34'h2_0000_0000; ecnt[1] = 6'd33; eadj[1] = 7'd21; ez[1] = 0;
      dv[2] = 34'h0_0000_0000; esm[2] = 34'h0_0000_0000; ecnt[2] = 6'd34; eadj[2] = 7'd22; ez[2] = 1;
      for (int i = 0; i < 3; i++) begin
         send_one(dv[i], 8'(8'hA0 + i), lat);
         checks++;
         if (lat !== L) $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, L);
         else passes++;
         checks++;
         if (out_sm !== esm[i] || out_count !== ecnt[i] || out_adj !== eadj[i] ||
             out_zero !== ez[i] || out_tag !== 8'(8'hA0 + i))
            $display("FAIL directed[%0d]: got sm=%h cnt=%0d adj=%h z=%b tag=%h expected sm=%h cnt=%0d adj=%h z=%b tag=%h",
                     i, out_sm, out_count, out_adj, out_zero, out_tag,
                     esm[i], ecnt[i], eadj[i], ez[i], 8'(8'hA0 + i));
         else passes++;
      end
   endtask

   task automatic run_stream(input bit bp);
      int sent, got, cyc, first_acc, first_out, last_out, extra, bad;
      bit hold;
      logic [33:0] h_sm, e_sm;
      logic [5:0]  h_cnt, e_cnt;
      logic [6:0]  h_adj, e_adj;
      logic        h_z, e_z;
      logic [7:0]  h_tag;
      sent = 0; got = 0; cyc = 0; first_acc = -1; first_out = -1; last_out = -1; hold = 0; bad = 0;
      h_sm = '0; h_cnt = '0; h_adj = '0; h_z = 0; h_tag = '0;
      while (got < 64 && cyc < 3000) begin
         @(negedge clk);
         flush = 0;
         in_valid = (sent < 64);
         in_sm = vec[(sent < 64) ? sent : 0];
         in_tag = 8'(sent);
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_sm !== h_sm || out_count !== h_cnt ||
                out_adj !== h_adj || out_zero !== h_z || out_tag !== h_tag)
               $display("FAIL stall_stable: got v=%b sm=%h cnt=%0d tag=%h expected v=1 sm=%h cnt=%0d tag=%h",
                        out_valid, out_sm, out_count, out_tag, h_sm, h_cnt, h_tag);
            else passes++;
         end
         if (out_valid && out_ready) begin
            ref_norm(vec[got], e_sm, e_cnt, e_adj, e_z);
            checks++;
            if (out_sm !== e_sm || out_count !== e_cnt || out_adj !== e_adj ||
                out_zero !== e_z || out_tag !== 8'(got))
               $display("FAIL stream[%0d]: got sm=%h cnt=%0d adj=%h z=%b tag=%h expected sm=%h cnt=%0d adj=%h z=%b tag=%h",
                        got, out_sm, out_count, out_adj, out_zero, out_tag,
                        e_sm, e_cnt, e_adj, e_z, 8'(got));
            else passes++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            got++;
         end
         hold = out_valid && !out_ready;
         h_sm = out_sm; h_cnt = out_count; h_adj = out_adj; h_z = out_zero; h_tag = out_tag;
         if (in_valid && in_ready) begin
            if (first_acc < 0) first_acc = cyc;
            sent++;
         end
         cyc++;
      end
      in_valid = 0;
      out_ready = 1;
      checks++;
      if (got !== 64) $display("FAIL stream_count: got %0d outputs expected 64", got);
      else passes++;
      if (!bp) begin
         checks++;
         if (first_out !== first_acc + L)
            $display("FAIL stream_fill: first output at cycle %0d expected %0d", first_out, first_acc + L);
         else passes++;
         checks++;
         if (last_out !== first_out + 63)
            $display("FAIL stream_rate: last output at cycle %0d expected %0d", last_out, first_out + 63);
         else passes++;
      end
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      checks++;
      if (extra !== 0) $display("FAIL stream_duplicates: got %0d extra outputs expected 0", extra);
      else passes++;
   endtask

   task automatic test_stream();
      run_stream(1'b0);
   endtask

   task automatic test_backpressure();
      run_stream(1'b1);
   endtask

   task automatic test_flush();
      int lat, extra;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         flush = 0; in_valid = 1; in_sm = 34'h1 << i; in_tag = 8'(i); out_ready = 1;
      end
      @(negedge clk);
      flush = 1; in_valid = 1; in_sm = 34'h5; in_tag = 8'hEE;
      #1;
      checks++;
      if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b expected 0", in_ready);
      else passes++;
      @(negedge clk);
      flush = 0; in_valid = 0;
      #1;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", out_valid);
      else passes++;
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      checks++;
      if (extra !== 0) $display("FAIL flush_survivors: got %0d outputs expected 0", extra);
      else passes++;
      send_one(34'h0_0000_0400, 8'h77, lat);
      checks++;
      if (lat !== L) $display("FAIL flush_next_latency: got %0d expected %0d", lat, L);
      else passes++;
      checks++;
      if (out_count !== 6'd23 || out_sm !== 34'h2_0000_0000 || out_adj !== 7'd11 || out_tag !== 8'h77)
         $display("FAIL flush_next_entry: got cnt=%0d sm=%h adj=%h tag=%h expected cnt=23 sm=200000000 adj=0b tag=77",
                  out_count, out_sm, out_adj, out_tag);
      else passes++;
   endtask

   task automatic test_async_reset();
      int lat;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         flush = 0; in_valid = 1; in_sm = 34'h3 << (4 * i); in_tag = 8'(8'h40 + i); out_ready = 1;
      end
      @(negedge clk);
      in_valid = 0;
      #1;
      checks++;
      if (out_valid !== 1'b1) $display("FAIL areset_pre_valid: got %b expected 1", out_valid);
      else passes++;
      #2;
      reset_n = 0;
      #1;
      checks++;
      if ({out_valid, out_sm, out_count, out_adj, out_zero, out_tag} !== '0)
         $display("FAIL areset_outputs: got v=%b sm=%h cnt=%0d adj=%h z=%b tag=%h expected all 0",
                  out_valid, out_sm, out_count, out_adj, out_zero, out_tag);
      else passes++;
      @(negedge clk);
      reset_n = 1;
      send_one(34'h3_0000_0000, 8'h99, lat);
      checks++;
      if (lat !== L) $display("FAIL areset_next_latency: got %0d expected %0d", lat, L);
      else passes++;
      checks++;
      if (out_count !== 6'd0 || out_sm !== 34'h3_0000_0000 || out_adj !== 7'h74 ||
          out_zero !== 1'b0 || out_tag !== 8'h99)
         $display("FAIL areset_next_entry: got cnt=%0d sm=%h adj=%h z=%b tag=%h expected cnt=0 sm=300000000 adj=74 z=0 tag=99",
                  out_count, out_sm, out_adj, out_zero, out_tag);
      else passes++;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         logic [63:0] r;
         r = {$urandom, $urandom};
         vec[i] = 34'(r >> (30 + $urandom_range(0, 34)));
      end
      vec[5]  = 34'h0;
      vec[17] = 34'h1;
      vec[40] = 34'h3_FFFF_FFFF;
      test_reset();
      test_directed();
      test_stream();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
